// File: rtl/riscv_fetch_unit.sv
// Decoupled RISC-V instruction fetch: a request/response imem port, a prefetch FIFO of
// {pc, instr} entries, and epoch-tagged redirects so stale responses are discarded.
module riscv_fetch_unit #(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0,
    localparam int AW        = $clog2(IMEM_DEPTH) + 2,
    localparam int PW        = $clog2(FIFO_DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic            clk,
    input  logic            RST_n,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [AW-1:0]   imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [31:0]     fetch_instr,
    output logic [CW-1:0]   fifo_count,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] req_pc_reg;
    logic [AW-1:0] inflight_pc_reg;
    logic          inflight_reg;
    logic          tag_reg;
    logic          epoch_reg;
    logic          misalign_reg;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          valid_reg;
    logic [AW-1:0] head_pc_reg;
    logic [31:0]   head_instr_reg;

    logic [AW-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]   instr_mem [FIFO_DEPTH];

    logic          req;
    logic          push;
    logic          pop;
    logic [AW-1:0] redirect_target;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          head_hit;
    logic [AW-1:0] head_pc_next;
    logic [31:0]   head_instr_next;
    logic          unused_pc_bits;

    assign unused_pc_bits  = ^redirect_pc[XLEN-1:AW];
    assign redirect_target = {redirect_pc[AW-1:2], 2'b00};

    // Credits count both queued entries and the one response still on its way;
    // a pop this cycle only frees a credit from the next cycle on.
    assign req = (state_reg == RUN) && !halt && !redirect_valid &&
                 (({1'b0, count_reg} + (CW+1)'(inflight_reg)) < (CW+1)'(FIFO_DEPTH));

    assign push = imem_rvalid && inflight_reg && (tag_reg == epoch_reg) && !redirect_valid;
    assign pop  = valid_reg && fetch_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PW'(push);
        rd_ptr_next = rd_ptr_reg + PW'(pop);
        count_next  = count_reg + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    // The head registers preload the entry that will be at the head after this edge,
    // taking it straight from the incoming response when it lands in that slot.
    always_comb begin
        head_hit        = push && (wr_ptr_reg == rd_ptr_next);
        head_pc_next    = head_pc_reg;
        head_instr_next = head_instr_reg;
        if (count_next != '0) begin
            if (head_hit) begin
                head_pc_next    = inflight_pc_reg;
                head_instr_next = imem_rdata;
            end else begin
                head_pc_next    = pc_mem[rd_ptr_next];
                head_instr_next = instr_mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_reg       <= BOOT;
            req_pc_reg      <= AW'(RESET_PC);
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            tag_reg         <= 1'b0;
            epoch_reg       <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            misalign_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid) begin
                state_reg <= halt ? HALTED : RUN;
            end else begin
                case (state_reg)
                    BOOT:    state_reg <= RUN;
                    RUN:     state_reg <= halt ? HALTED : RUN;
                    HALTED:  state_reg <= halt ? HALTED : RUN;
                    default: state_reg <= BOOT;
                endcase
            end

            if (redirect_valid) begin
                req_pc_reg <= redirect_target;
                epoch_reg  <= ~epoch_reg;
            end else if (req) begin
                req_pc_reg <= req_pc_reg + AW'(4);
            end

            if (req) begin
                inflight_reg    <= 1'b1;
                inflight_pc_reg <= req_pc_reg;
                tag_reg         <= epoch_reg;
            end else if (imem_rvalid) begin
                inflight_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            valid_reg      <= 1'b0;
            head_pc_reg    <= '0;
            head_instr_reg <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            valid_reg      <= (count_next != '0);
            head_pc_reg    <= head_pc_next;
            head_instr_reg <= head_instr_next;
        end
    end

    assign imem_req     = req;
    assign imem_addr    = req_pc_reg;
    assign fetch_valid  = valid_reg;
    assign fetch_pc     = XLEN'(head_pc_reg);
    assign fetch_instr  = head_instr_reg;
    assign fifo_count   = count_reg;
    assign misalign_err = misalign_reg;

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Parametrised, decoupled instruction-fetch stage for the next-generation RISC-V core. It replaces the combinational PC register and instruction-ROM path with a request/response memory interface, a prefetch FIFO of {pc, instr} entries and epoch-tagged redirects, so fetch keeps running while decode stalls on a cache miss. It sits between the instruction memory and the decode/control stage, and takes redirects from branch and jump resolution.

Parameters:
XLEN, 32, datapath and PC width
IMEM_DEPTH, 256, instruction memory words; power of two, >=4
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 0, PC after reset; word-aligned, < IMEM_DEPTH*4
AW, $clog2(IMEM_DEPTH)+2, byte-address width (derived; not overridable)

Ports:
clk  in  1  clock, rising edge
RST_n  in  1  asynchronous active-low reset
halt  in  1  level; blocks new memory requests
redirect_valid  in  1  one-cycle redirect strobe
redirect_pc  in  XLEN  redirect target, byte address
imem_req  out  1  instruction read request
imem_addr  out  AW  request byte address, bits [1:0] always 0
imem_rvalid  in  1  response strobe, exactly 1 cycle after imem_req
imem_rdata  in  32  response instruction
fetch_valid  out  1  FIFO head valid
fetch_ready  in  1  decode accepts head
fetch_pc  out  XLEN  head PC, zero-extended from AW
fetch_instr  out  32  head instruction
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
misalign_err  out  1  one-cycle pulse on a misaligned redirect

Behaviour:
- Reset (asynchronous, RST_n=0): next-request PC = RESET_PC; FIFO empty; inflight=0; epoch=0; state=BOOT. Outputs: fetch_valid=0, imem_req=0, imem_addr=RESET_PC, fifo_count=0, misalign_err=0, fetch_pc=0, fetch_instr=0.
- FSM, three states:
  - BOOT: one cycle, no request, goes to RUN.
  - RUN: normal operation; halt=1 goes to HALTED.
  - HALTED: no requests; halt=0 returns to RUN.
- Redirect in any state: stays in or enters RUN unless halt=1.
- Request rule: imem_req=1 when state=RUN, halt=0, redirect_valid=0 and (fifo_count + inflight) < FIFO_DEPTH. A pop in the same cycle does not free a credit.
- On each request: imem_addr = request PC; the request PC advances by 4 modulo IMEM_DEPTH*4, so 0x3FC wraps to 0x000 at depth 256; a tag {epoch} is registered; inflight=1.
- Response path:
  - imem_rvalid with tag == epoch is written at that edge as {pc, imem_rdata}.
  - A mismatched tag is dropped.
  - inflight clears unless a new request is issued in the same cycle.
  - imem_rvalid with inflight=0 is ignored.
- Output timing:
  - FIFO outputs are registered, with no bypass.
  - Request in cycle k, response in k+1, fetch_valid visible in k+2.
  - With fetch_ready held at 1, one instruction is delivered per cycle.
- Handshake: a pop occurs when fetch_valid && fetch_ready. fetch_pc and fetch_instr stay stable while fetch_valid=1 and fetch_ready=0.
- Push and pop in the same cycle: fifo_count is unchanged. Full FIFO: no overflow is possible because of the credit rule. Empty FIFO: fetch_valid=0, and fetch_pc/fetch_instr hold their last values.
- Redirect at edge N:
  - FIFO flushed (fifo_count=0); epoch toggles; request PC = {redirect_pc[AW-1:2], 2'b00}.
  - No request in cycle N; the first request is in N+1, and fetch_valid is back at N+3.
  - A pop in the redirect cycle still completes.
  - A response arriving in the redirect cycle is dropped.
  - Redirect has priority over push.
- Misaligned redirect: redirect_pc[1:0] != 0 gives misalign_err=1 for the cycle after the edge, and the target is aligned down.
- Redirect while HALTED: updates the request PC and flushes; no requests until halt=0.
- Upper redirect_pc bits above AW-1 are ignored.

Test Plan:
- Reset then stream, RESET_PC=0, fetch_ready=1, ROM[i]=i: fetch_valid rises 2 cycles after the first request; pairs (0x0,0),(0x4,1),(0x8,2) arrive on consecutive cycles; assert RST_n mid-stream -> all outputs return to their reset values within the same cycle.
- Backpressure, fetch_ready=0 for 10 cycles: fifo_count reaches 4, imem_req=0, head stays at pc 0x0; release -> pcs 0x0..0x1C delivered in order, none lost or duplicated.
- Redirect to 0x40 while the response for 0x10 is in flight: the 0x10 data is never presented; the next fetch_pc is 0x40, visible 3 cycles after the redirect edge.
- Misaligned redirect to 0x42: misalign_err pulses once; fetch_pc is 0x40 then 0x44.
- Wrap, IMEM_DEPTH=256, redirect to 0x3F8: fetch_pc sequence 0x3F8, 0x3FC, 0x000.
- halt=1 for 5 cycles mid-stream: no imem_req; the in-flight response is still queued; halt=0 resumes at the next sequential PC.
